sequence_generator: RTL
=======================

Name: sequence_generator

Overview:
- Transmit-side counterpart of the serial sequence detector.
- On a button press it snapshots an 8-bit switch word and shifts it out serially, MSB first, one bit per BIT_DIV clocks.
- Each bit period is marked by a one-cycle bit strobe, so the stream can drive the detector's serial input or an LED for visual check.
- Supports 1-4 back-to-back frame repeats separated by an idle gap, then reports completion.

Parameters:
- WIDTH, 8, bits per frame (shift register and bit counter sized from it).
- BIT_DIV, 4, clocks per serial bit (≥1); divider width $clog2(BIT_DIV)+1.
- GAP_CYCLES, 3, clocks of forced-low gap between repeated frames (≥1).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- button  input  1  start request, synchronous level; only its rising edge acts.
- switch  input  WIDTH  frame word, sampled on start only.
- rep  input  2  repeat count; frames sent = rep+1; sampled on start only.
- serial_out  output  1  serial data, MSB first.
- bit_valid  output  1  one-cycle pulse on the first clock of every bit period.
- busy  output  1  high from the cycle after start until DONE is left.
- done  output  1  one-cycle pulse after the last bit of the last frame.
- led  output  1  sticky completion indicator; cleared by next start.

Behaviour:
- Reset (async): state=IDLE, serial_out=0, bit_valid=0, busy=0, done=0, led=0, all counters=0, btn_q=0.
- Edge detect: btn_q <= button each clk; start = button & ~btn_q. A held button causes exactly one start.
- States (one-hot): IDLE, SHIFT, GAP, DONE.
- IDLE: on start, load sh<=switch, word<=switch, frames_left<=rep, bit_cnt<=0, div_cnt<=0; go to SHIFT. serial_out stays 0 in IDLE.
- SHIFT, latency: serial_out=switch[WIDTH-1] and bit_valid=1 on the clock edge after start. Total latency is one cycle.
- SHIFT, bit timing: each bit is held BIT_DIV cycles. When div_cnt==BIT_DIV-1, shift left, increment bit_cnt, and raise bit_valid for the next cycle.
- SHIFT, frame end: after bit WIDTH-1 completes its period, go to GAP if frames_left!=0, else go to DONE.
- GAP: serial_out=0, bit_valid=0 for GAP_CYCLES cycles. Then reload sh<=word, decrement frames_left, return to SHIFT; the first bit restarts with bit_valid.
- DONE: one cycle; done=1, led<=1, busy stays 1; next state IDLE.
- Start during SHIFT/GAP/DONE: abort the current frame and restart as from IDLE with a new switch/rep snapshot. led<=0. No done pulse for the aborted transfer.
- Start also clears led in IDLE.
- Switch/rep changes mid-transfer are ignored.
- Reset mid-transfer returns to IDLE immediately; no done pulse.
- Outputs are all registered; no combinational path from inputs to outputs.
- Frame length in clocks = WIDTH*BIT_DIV. Total busy = (rep+1)*WIDTH*BIT_DIV + rep*GAP_CYCLES + 1.

Decomposition:
- Shared package seq_pkg holds:
  - State encoding constants IDLE/SHIFT/GAP/DONE (one-hot, 4 bits).
  - Default WIDTH=8.
  - Detector pattern constant PATTERN=5'b10010, shared with the detector bench.
- One natural sub-module: button_edge (btn_q register plus rising-edge output), reusable by the detector.
- Divider, bit counter and FSM stay in the top module.

Test Plan:
- Reset, then button high for 1 cycle with switch=8'hA5, rep=0, BIT_DIV=4:
  - serial_out follows 1,0,1,0,0,1,0,1, each bit held 4 clocks.
  - 8 bit_valid pulses, 4 clocks apart.
  - done pulses once at cycle 34 after start; led=1; busy high 33 cycles.
- switch=8'h12, rep=2:
  - Three identical frames 00010010, each separated by 3 low gap cycles.
  - 24 bit_valid pulses; single done; busy = 3*32+2*3+1 = 103 cycles.
- Button held high for 50 cycles with switch=8'hFF:
  - Exactly one frame sent and one done pulse; no restart.
- Second button press at bit 3 of frame with switch=8'h0F:
  - Stream restarts at new MSB on the next cycle, no done for the aborted frame, led stays 0 until the new done.
- rst asserted mid-SHIFT:
  - All outputs 0 asynchronously, state IDLE; the next press starts cleanly.
- Loopback: generator serial_out and bit_valid feed the detector, switch=8'b00100101 (contains 10010):
  - Detector led=1.
  - With 8'hFF, detector led stays 0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence generator and its companion detector.
package seq_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Pattern the detector searches for; the generator bench uses it for loopback checks.
  localparam logic [4:0] PATTERN = 5'b10010;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    SHIFT = 4'b0010,
    GAP   = 4'b0100,
    DONE  = 4'b1000
  } state_e;

endpackage

// File: rtl/sequence_generator_if.sv
// Control and serial-stream signals of the sequence generator.
interface sequence_generator_if #(
  parameter int WIDTH = seq_pkg::DEFAULT_WIDTH
);
  logic             button;
  logic [WIDTH-1:0] switch;
  logic [1:0]       rep;
  logic             serial_out;
  logic             bit_valid;
  logic             busy;
  logic             done;
  logic             led;

  modport master (
    output button, switch, rep,
    input  serial_out, bit_valid, busy, done, led
  );

  modport slave (
    input  button, switch, rep,
    output serial_out, bit_valid, busy, done, led
  );
endinterface

// File: rtl/button_edge.sv
// Registers a level button and flags its rising edge, so a held button starts only once.
module button_edge (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic start
);

  logic btn_q;
  logic btn_d;

  always_comb begin
    btn_d = button;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn_d;
    end
  end

  assign start = button & ~btn_q;

endmodule

// File: rtl/sequence_generator.sv
// Snapshots a switch word on a button press and shifts it out MSB first,
// one bit per BIT_DIV clocks, repeated rep+1 times with idle gaps between frames.
module sequence_generator
  import seq_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int BIT_DIV    = 4,
  parameter int GAP_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  sequence_generator_if.slave  bus
);

  localparam int DIV_W = $clog2(BIT_DIV) + 1;
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [1:0]       frames_left_q, frames_left_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

  logic serial_out_q, serial_out_d;
  logic bit_valid_q, bit_valid_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic led_q, led_d;

  logic start;

  button_edge u_button_edge (
    .clk    (clk),
    .rst    (rst),
    .button (bus.button),
    .start  (start)
  );

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_d       = state_q;
    sh_d          = sh_q;
    word_d        = word_q;
    frames_left_d = frames_left_q;
    bit_cnt_d     = bit_cnt_q;
    div_cnt_d     = div_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    bit_valid_d   = 1'b0;
    done_d        = 1'b0;
    led_d         = led_q;

    if (start) begin
      // A press in any state restarts from a fresh snapshot and drops the old transfer.
      state_d       = SHIFT;
      sh_d          = bus.switch;
      word_d        = bus.switch;
      frames_left_d = bus.rep;
      bit_cnt_d     = '0;
      div_cnt_d     = '0;
      gap_cnt_d     = '0;
      bit_valid_d   = 1'b1;
      led_d         = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end

        SHIFT: begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            if (bit_cnt_q == BIT_LAST) begin
              if (frames_left_q != 2'd0) begin
                state_d   = GAP;
                gap_cnt_d = '0;
              end else begin
                state_d = DONE;
                done_d  = 1'b1;
                led_d   = 1'b1;
              end
            end else begin
              sh_d        = sh_q << 1;
              bit_cnt_d   = bit_cnt_q + 1'b1;
              bit_valid_d = 1'b1;
            end
          end else begin
            div_cnt_d = div_cnt_q + 1'b1;
          end
        end

        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_d       = SHIFT;
            sh_d          = word_q;
            frames_left_d = frames_left_q - 2'd1;
            bit_cnt_d     = '0;
            div_cnt_d     = '0;
            gap_cnt_d     = '0;
            bit_valid_d   = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end

        DONE: begin
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    serial_out_d = (state_d == SHIFT) & sh_d[WIDTH-1];
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sh_q          <= '0;
      word_q        <= '0;
      frames_left_q <= '0;
      bit_cnt_q     <= '0;
      div_cnt_q     <= '0;
      gap_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      sh_q          <= sh_d;
      word_q        <= word_d;
      frames_left_q <= frames_left_d;
      bit_cnt_q     <= bit_cnt_d;
      div_cnt_q     <= div_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      serial_out_q <= 1'b0;
      bit_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      led_q        <= 1'b0;
    end else begin
      serial_out_q <= serial_out_d;
      bit_valid_q  <= bit_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      led_q        <= led_d;
    end
  end

  assign bus.serial_out = serial_out_q;
  assign bus.bit_valid  = bit_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.led        = led_q;

endmodule
